// File: rtl/sram_bank_controller.sv
// 68k SRAM bank controller: decodes the bank from the upper address bits and sequences
// OE/WE/UB/LB strobes through SETUP, programmable WAIT, ACK (Dtack) and RECOVER.
module sram_bank_controller #(
  parameter int ADDR_WIDTH  = 17,
  parameter int NUM_BANKS   = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic                  Clock,
  input  logic                  Reset_L,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  SRamSelect_H,
  input  logic                  AS_L,
  input  logic                  UDS_L,
  input  logic                  LDS_L,
  input  logic                  RW,
  output logic [NUM_BANKS-1:0]  BlockSel_H,
  output logic                  SRam_OE_L,
  output logic                  SRam_WE_L,
  output logic                  SRam_UB_L,
  output logic                  SRam_LB_L,
  output logic                  Dtack_L,
  output logic                  Busy_H
);
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_ACK,
    ST_RECOVER
  } state_t;

  state_t                state_reg, state_next;
  logic [3:0]            count_reg, count_next;
  logic [BANK_BITS-1:0]  bank_reg, bank_next;
  logic                  rw_reg, rw_next;
  logic                  uds_reg, uds_next;
  logic                  lds_reg, lds_next;
  logic                  request;
  logic [NUM_BANKS-1:0]  bank_hit;
  logic [NUM_BANKS-1:0]  block_sel_next;
  logic                  oe_next, we_next, ub_next, lb_next, dtack_next, busy_next;
  logic                  addr_unused;

  assign request = SRamSelect_H & ~AS_L & (~UDS_L | ~LDS_L);

  // Word offset within a bank goes straight to the SRAM chips, not through this block.
  assign addr_unused = ^Address[ADDR_WIDTH-BANK_BITS-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_decode
      assign bank_hit[gi] = (bank_next == BANK_BITS'(gi));
    end
  endgenerate

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      bank_reg  <= '0;
      rw_reg    <= 1'b1;
      uds_reg   <= 1'b1;
      lds_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      bank_reg  <= bank_next;
      rw_reg    <= rw_next;
      uds_reg   <= uds_next;
      lds_reg   <= lds_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    bank_next  = bank_reg;
    rw_next    = rw_reg;
    uds_next   = uds_reg;
    lds_next   = lds_reg;
    case (state_reg)
      ST_IDLE: begin
        if (request) begin
          state_next = ST_SETUP;
          bank_next  = Address[ADDR_WIDTH-1 -: BANK_BITS];
          rw_next    = RW;
          uds_next   = UDS_L;
          lds_next   = LDS_L;
        end
      end
      ST_SETUP: begin
        if (AS_L) begin
          state_next = ST_RECOVER;
        end else if (WAIT_STATES > 0) begin
          state_next = ST_WAIT;
          count_next = WAIT_LOAD;
        end else begin
          state_next = ST_ACK;
        end
      end
      ST_WAIT: begin
        // An abort wins over a completing wait so Dtack is never issued for it.
        if (AS_L) begin
          state_next = ST_RECOVER;
        end else if (count_reg == 4'd0) begin
          state_next = ST_ACK;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      ST_ACK: begin
        if (AS_L) begin
          state_next = ST_RECOVER;
        end
      end
      ST_RECOVER: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the pins are glitch-free.
  always_comb begin
    block_sel_next = '0;
    oe_next        = 1'b1;
    we_next        = 1'b1;
    ub_next        = 1'b1;
    lb_next        = 1'b1;
    dtack_next     = 1'b1;
    busy_next      = (state_next != ST_IDLE);
    if (state_next == ST_SETUP || state_next == ST_WAIT || state_next == ST_ACK) begin
      block_sel_next = bank_hit;
      ub_next        = uds_next;
      lb_next        = lds_next;
      oe_next        = ~rw_next;
    end
    if (state_next == ST_WAIT || state_next == ST_ACK) begin
      we_next = rw_next;
    end
    if (state_next == ST_ACK) begin
      dtack_next = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      BlockSel_H <= '0;
      SRam_OE_L  <= 1'b1;
      SRam_WE_L  <= 1'b1;
      SRam_UB_L  <= 1'b1;
      SRam_LB_L  <= 1'b1;
      Dtack_L    <= 1'b1;
      Busy_H     <= 1'b0;
    end else begin
      BlockSel_H <= block_sel_next;
      SRam_OE_L  <= oe_next;
      SRam_WE_L  <= we_next;
      SRam_UB_L  <= ub_next;
      SRam_LB_L  <= lb_next;
      Dtack_L    <= dtack_next;
      Busy_H     <= busy_next;
    end
  end

endmodule

// File: tb/tb_sram_bank_controller.sv
// Bench for sram_bank_controller: three parameterisations share one stimulus stream and are
// checked every cycle against an access-age model, plus directed literal checks.
module tb_sram_bank_controller;
  logic        Clock = 1'b0;
  logic        Reset_L = 1'b1;
  logic [16:0] Address = '0;
  logic        SRamSelect_H = 1'b0;
  logic        AS_L = 1'b1;
  logic        UDS_L = 1'b1;
  logic        LDS_L = 1'b1;
  logic        RW = 1'b1;

  logic [3:0]  bs_a, bs_b;
  logic [7:0]  bs_c;
  logic        oe_a, we_a, ub_a, lb_a, dt_a, busy_a;
  logic        oe_b, we_b, ub_b, lb_b, dt_b, busy_b;
  logic        oe_c, we_c, ub_c, lb_c, dt_c, busy_c;

  int n_cmp = 0;
  int n_fail = 0;

  sram_bank_controller #(.ADDR_WIDTH(17), .NUM_BANKS(4), .WAIT_STATES(1)) dut_a (
    .Clock(Clock), .Reset_L(Reset_L), .Address(Address), .SRamSelect_H(SRamSelect_H),
    .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW), .BlockSel_H(bs_a),
    .SRam_OE_L(oe_a), .SRam_WE_L(we_a), .SRam_UB_L(ub_a), .SRam_LB_L(lb_a),
    .Dtack_L(dt_a), .Busy_H(busy_a));

  sram_bank_controller #(.ADDR_WIDTH(17), .NUM_BANKS(4), .WAIT_STATES(3)) dut_b (
    .Clock(Clock), .Reset_L(Reset_L), .Address(Address), .SRamSelect_H(SRamSelect_H),
    .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW), .BlockSel_H(bs_b),
    .SRam_OE_L(oe_b), .SRam_WE_L(we_b), .SRam_UB_L(ub_b), .SRam_LB_L(lb_b),
    .Dtack_L(dt_b), .Busy_H(busy_b));

  sram_bank_controller #(.ADDR_WIDTH(17), .NUM_BANKS(8), .WAIT_STATES(0)) dut_c (
    .Clock(Clock), .Reset_L(Reset_L), .Address(Address), .SRamSelect_H(SRamSelect_H),
    .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW), .BlockSel_H(bs_c),
    .SRam_OE_L(oe_c), .SRam_WE_L(we_c), .SRam_UB_L(ub_c), .SRam_LB_L(lb_c),
    .Dtack_L(dt_c), .Busy_H(busy_c));

  initial forever #5 Clock = ~Clock;

  // Model: an access is either absent, active with an age in clocks since it was
  // sampled, or in its single recovery clock.
  int         ws_tab [3] = '{1, 3, 0};
  bit         m_active [3] = '{default: 1'b0};
  bit         m_recover [3] = '{default: 1'b0};
  int         m_age [3] = '{default: 0};
  logic [2:0] m_bank [3] = '{default: 3'd0};
  logic       m_rw [3] = '{default: 1'b1};
  logic       m_uds [3] = '{default: 1'b1};
  logic       m_lds [3] = '{default: 1'b1};

  always @(posedge Clock or negedge Reset_L) begin
    for (int i = 0; i < 3; i++) begin
      if (!Reset_L) begin
        m_active[i]  <= 1'b0;
        m_recover[i] <= 1'b0;
        m_age[i]     <= 0;
      end else if (m_recover[i]) begin
        m_recover[i] <= 1'b0;
      end else if (m_active[i]) begin
        if (AS_L) begin
          m_active[i]  <= 1'b0;
          m_recover[i] <= 1'b1;
        end else if (m_age[i] < ws_tab[i] + 1) begin
          m_age[i] <= m_age[i] + 1;
        end
      end else if (SRamSelect_H && !AS_L && (!UDS_L || !LDS_L)) begin
        m_active[i] <= 1'b1;
        m_age[i]    <= 0;
        m_bank[i]   <= (i == 2) ? Address[16:14] : {1'b0, Address[16:15]};
        m_rw[i]     <= RW;
        m_uds[i]    <= UDS_L;
        m_lds[i]    <= LDS_L;
      end
    end
  end

  function automatic logic [13:0] expect_out(int i);
    logic [7:0] bs;
    logic oe, we, ub, lb, dt, busy;
    bs = '0; oe = 1'b1; we = 1'b1; ub = 1'b1; lb = 1'b1; dt = 1'b1;
    busy = m_active[i] | m_recover[i];
    if (m_active[i]) begin
      bs[m_bank[i]] = 1'b1;
      ub = m_uds[i];
      lb = m_lds[i];
      oe = ~m_rw[i];
      if (!m_rw[i] && m_age[i] >= 1) we = 1'b0;
      if (m_age[i] >= ws_tab[i] + 1) dt = 1'b0;
    end
    return {bs, oe, we, ub, lb, dt, busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  logic [13:0] act_out [3];
  always @(negedge Clock) begin
    act_out[0] = {4'b0, bs_a, oe_a, we_a, ub_a, lb_a, dt_a, busy_a};
    act_out[1] = {4'b0, bs_b, oe_b, we_b, ub_b, lb_b, dt_b, busy_b};
    act_out[2] = {bs_c, oe_c, we_c, ub_c, lb_c, dt_c, busy_c};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cycle dut%0d", i), 32'(act_out[i]), 32'(expect_out(i)));
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic go_idle();
    SRamSelect_H = 1'b0; AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1; RW = 1'b1;
    repeat (3) step();
  endtask

  task automatic request(input logic [16:0] addr, input logic rw, input logic uds, input logic lds);
    Address = addr; RW = rw; UDS_L = uds; LDS_L = lds; SRamSelect_H = 1'b1; AS_L = 1'b0;
  endtask

  initial begin
    #1 Reset_L = 1'b0;
    #1;
    check("reset a", 32'({bs_a, oe_a, we_a, ub_a, lb_a, dt_a, busy_a}), 32'({4'h0, 6'b111110}));
    check("reset c", 32'(bs_c), 32'h0);
    #5 Reset_L = 1'b1;
    step();

    // Read from bank 2 with one wait state
    request(17'h10000, 1'b1, 1'b0, 1'b0);
    step();
    check("t1 setup blocksel", 32'(bs_a), 32'h4);
    check("t1 setup oe", 32'(oe_a), 32'h0);
    check("t1 setup dtack", 32'(dt_a), 32'h1);
    step();
    check("t1 wait dtack", 32'(dt_a), 32'h1);
    step();
    check("t1 ack dtack", 32'(dt_a), 32'h0);
    step();
    check("t1 ack held", 32'(dt_a), 32'h0);
    AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    step();
    check("t1 recover outs", 32'({bs_a, oe_a, we_a, ub_a, lb_a, dt_a, busy_a}), 32'({4'h0, 6'b111111}));
    step();
    check("t1 idle busy", 32'(busy_a), 32'h0);
    go_idle();

    // Lower byte write to bank 3
    request(17'h1FFFE, 1'b0, 1'b1, 1'b0);
    step();
    check("t2 setup", 32'({bs_a, oe_a, we_a, ub_a, lb_a}), 32'({4'b1000, 4'b1110}));
    step();
    check("t2 wait we/oe", 32'({oe_a, we_a}), 32'b10);
    step();
    check("t2 ack we/dtack", 32'({oe_a, we_a, dt_a}), 32'b100);
    AS_L = 1'b1;
    step();
    check("t2 recover we", 32'({bs_a, we_a}), 32'({4'h0, 1'b1}));
    go_idle();

    // Abort during WAIT on the three-wait-state instance
    request(17'h00000, 1'b1, 1'b0, 1'b0);
    step();
    step();
    check("t3 wait dtack", 32'(dt_b), 32'h1);
    step();
    AS_L = 1'b1;
    step();
    check("t3 recover", 32'({bs_b, dt_b, busy_b}), 32'({4'h0, 2'b11}));
    step();
    check("t3 idle busy", 32'(busy_b), 32'h0);
    go_idle();

    // Asynchronous reset in the middle of ACK
    request(17'h08000, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    check("t4 ack before reset", 32'(dt_a), 32'h0);
    #2 Reset_L = 1'b0;
    #1;
    check("t4 reset a", 32'({bs_a, oe_a, we_a, ub_a, lb_a, dt_a, busy_a}), 32'({4'h0, 6'b111110}));
    check("t4 reset b/c", 32'({bs_b, bs_c, busy_b, busy_c}), 32'h0);
    AS_L = 1'b1;
    Reset_L = 1'b1;
    step();
    request(17'h08000, 1'b1, 1'b0, 1'b0);
    step();
    check("t4 post setup blocksel", 32'(bs_a), 32'h2);
    step();
    step();
    check("t4 post ack", 32'(dt_a), 32'h0);
    go_idle();

    // No request: strobes idle, then SRAM not selected
    SRamSelect_H = 1'b1; AS_L = 1'b0; UDS_L = 1'b1; LDS_L = 1'b1;
    repeat (2) step();
    check("t5 no strobe", 32'({bs_a, dt_a, busy_a}), 32'({4'h0, 2'b10}));
    SRamSelect_H = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0;
    repeat (2) step();
    check("t5 no select", 32'({bs_c, dt_c, busy_c}), 32'({8'h0, 2'b10}));
    go_idle();

    // Eight banks, no wait states
    request(17'h0E000, 1'b1, 1'b0, 1'b0);
    step();
    check("t6 setup blocksel", 32'(bs_c), 32'h08);
    check("t6 setup dtack", 32'(dt_c), 32'h1);
    step();
    check("t6 ack", 32'({oe_c, dt_c}), 32'b00);
    go_idle();

    // Randomised traffic with hold-time, abort and reset variation
    for (int t = 0; t < 300; t++) begin
      request(17'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      SRamSelect_H = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(1, 8)) begin
        step();
        if ($urandom_range(0, 3) == 0) Address = 17'($urandom);
        if ($urandom_range(0, 5) == 0) SRamSelect_H = 1'($urandom);
        if ($urandom_range(0, 5) == 0) RW = 1'($urandom);
        if ($urandom_range(0, 59) == 0) begin
          #2 Reset_L = 1'b0;
          #1 Reset_L = 1'b1;
        end
      end
      AS_L = 1'b1;
      repeat ($urandom_range(1, 3)) step();
    end
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
